// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined RV32I shift unit.
package shift_pkg;
  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b11
  } shift_op_t;

  localparam int DEFAULT_NB_BITS_DATA = 32;
  localparam int DEFAULT_REG_EVERY    = 2;
endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// One fixed-distance barrel stage: shifts by SHIFT_DIST when enabled, else passes through.
module barrel_stage
  import shift_pkg::*;
#(
  parameter int NB_BITS_DATA = DEFAULT_NB_BITS_DATA,
  parameter int SHIFT_DIST   = 1
) (
  input  logic [NB_BITS_DATA-1:0] data_i,
  input  logic                    en_i,
  input  logic                    dir_i,
  input  logic                    fill_i,
  output logic [NB_BITS_DATA-1:0] data_o
);
  always_comb begin
    data_o = data_i;
    if (en_i) begin
      if (dir_i) data_o = {{SHIFT_DIST{fill_i}}, data_i[NB_BITS_DATA-1:SHIFT_DIST]};
      else       data_o = {data_i[NB_BITS_DATA-SHIFT_DIST-1:0], {SHIFT_DIST{1'b0}}};
    end
  end
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Multi-cycle SLL/SRL/SRA unit: log2 fixed stages, a register slot every REG_EVERY stages, valid/ready at both ends.
module pipelined_barrel_shifter
  import shift_pkg::*;
#(
  parameter int NB_BITS_DATA  = DEFAULT_NB_BITS_DATA,
  parameter int NB_BITS_SHIFT = $clog2(NB_BITS_DATA),
  parameter int REG_EVERY     = DEFAULT_REG_EVERY,
  parameter int NB_BITS_TAG   = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [1:0]               op_i,
  input  logic [NB_BITS_DATA-1:0]  data_i,
  input  logic [NB_BITS_SHIFT-1:0] shamt_i,
  input  logic [NB_BITS_TAG-1:0]   tag_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [NB_BITS_DATA-1:0]  data_o,
  output logic [NB_BITS_TAG-1:0]   tag_o
);
  localparam int NB_SLOTS = (NB_BITS_SHIFT + REG_EVERY - 1) / REG_EVERY;
  localparam int L        = NB_SLOTS - 1;

  logic [NB_SLOTS-1:0] vld, ld;
  logic                fill_in;

  // Per-slot register contents and the operands each stage group works on
  logic [NB_BITS_DATA-1:0]  data_s    [NB_SLOTS];
  logic [NB_BITS_TAG-1:0]   tag_s     [NB_SLOTS];
  logic [1:0]               op_s      [NB_SLOTS];
  logic                     fill_s    [NB_SLOTS];
  logic [NB_BITS_SHIFT-1:0] shamt_s   [NB_SLOTS];
  logic                     src_vld   [NB_SLOTS];
  logic [NB_BITS_DATA-1:0]  src_data  [NB_SLOTS];
  logic [NB_BITS_TAG-1:0]   src_tag   [NB_SLOTS];
  logic [1:0]               src_op    [NB_SLOTS];
  logic                     src_fill  [NB_SLOTS];
  logic [NB_BITS_SHIFT-1:0] src_shamt [NB_SLOTS];
  logic [NB_BITS_DATA-1:0]  st_out    [NB_BITS_SHIFT];

  assign fill_in = (shift_op_t'(op_i) == SH_SRA) & data_i[NB_BITS_DATA-1];

  // A slot may load when empty or when its occupant moves on; resolved from the output backwards
  always_comb begin
    logic nxt;
    ld  = '0;
    nxt = out_ready_i;
    for (int s = NB_SLOTS - 1; s >= 0; s--) begin
      ld[s] = !vld[s] | nxt;
      nxt   = ld[s];
    end
  end

  assign in_ready_o  = ld[0] & ~flush_i;
  assign out_valid_o = vld[L];
  assign data_o      = data_s[L];
  assign tag_o       = tag_s[L];

  for (genvar k = 0; k < NB_BITS_SHIFT; k++) begin : g_stage
    localparam int G = k / REG_EVERY;
    logic [NB_BITS_DATA-1:0] st_in;
    if (k % REG_EVERY == 0) begin : g_head
      assign st_in = src_data[G];
    end else begin : g_body
      assign st_in = st_out[k-1];
    end
    barrel_stage #(.NB_BITS_DATA(NB_BITS_DATA), .SHIFT_DIST(1 << k)) u_stage (
      .data_i (st_in),
      .en_i   (src_shamt[G][k]),
      .dir_i  (src_op[G][0]),
      .fill_i (src_fill[G]),
      .data_o (st_out[k])
    );
  end

  for (genvar g = 0; g < NB_SLOTS; g++) begin : g_slot
    localparam int LAST = (((g + 1) * REG_EVERY < NB_BITS_SHIFT) ? (g + 1) * REG_EVERY : NB_BITS_SHIFT) - 1;
    logic                     vld_q, vld_d, fill_q;
    logic [1:0]               op_q;
    logic [NB_BITS_SHIFT-1:0] shamt_q;
    logic [NB_BITS_DATA-1:0]  data_q;
    logic [NB_BITS_TAG-1:0]   tag_q;
    logic                     unused_meta;

    if (g == 0) begin : g_src_in
      assign src_vld[g]   = in_valid_i & in_ready_o;
      assign src_data[g]  = data_i;
      assign src_tag[g]   = tag_i;
      assign src_op[g]    = op_i;
      assign src_fill[g]  = fill_in;
      assign src_shamt[g] = shamt_i;
    end else begin : g_src_prev
      assign src_vld[g]   = vld[g-1];
      assign src_data[g]  = data_s[g-1];
      assign src_tag[g]   = tag_s[g-1];
      assign src_op[g]    = op_s[g-1];
      assign src_fill[g]  = fill_s[g-1];
      assign src_shamt[g] = shamt_s[g-1];
    end

    always_comb begin
      vld_d = vld_q;
      if (flush_i)    vld_d = 1'b0;
      else if (ld[g]) vld_d = src_vld[g];
    end

    // Payload only moves with a valid op, so idle inputs never reach the registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        vld_q   <= 1'b0;
        op_q    <= '0;
        fill_q  <= 1'b0;
        shamt_q <= '0;
        data_q  <= '0;
        tag_q   <= '0;
      end else begin
        vld_q <= vld_d;
        if (ld[g] && src_vld[g]) begin
          op_q    <= src_op[g];
          fill_q  <= src_fill[g];
          shamt_q <= src_shamt[g];
          data_q  <= st_out[LAST];
          tag_q   <= src_tag[g];
        end
      end
    end

    assign vld[g]      = vld_q;
    assign data_s[g]   = data_q;
    assign tag_s[g]    = tag_q;
    assign op_s[g]     = op_q;
    assign fill_s[g]   = fill_q;
    assign shamt_s[g]  = shamt_q;
    // Already-consumed shamt bits and the last slot's metadata have no reader
    assign unused_meta = ^{op_q, fill_q, shamt_q};
  end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and randomized checks of the pipelined shift unit against hand values and a behavioural model.
module tb_pipelined_barrel_shifter;
  localparam int W  = 32;
  localparam int S  = 5;
  localparam int T  = 5;
  localparam int NR = 10000;

  logic         clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid;
  logic [1:0]   op = '0;
  logic [W-1:0] din = '0, dout;
  logic [S-1:0] sh = '0;
  logic [T-1:0] tag = '0, tago;

  int n_cmp = 0, n_err = 0;
  int sent = 0, cyc = 0;
  logic [W-1:0] q_d[$];
  logic [T-1:0] q_t[$];
  logic [1:0]   ro;
  logic [W-1:0] rd;
  logic [S-1:0] rs;
  logic [T-1:0] rt;

  logic [1:0]   t3op [8] = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10};
  logic [W-1:0] t3d  [8] = '{32'h0000_00FF, 32'hF000_0000, 32'hF000_0000, 32'h7000_0000,
                             32'h1234_5678, 32'h8000_0001, 32'h8000_0001, 32'h0000_0003};
  logic [S-1:0] t3s  [8] = '{5'd4, 5'd8, 5'd8, 5'd28, 5'd0, 5'd31, 5'd31, 5'd16};
  logic [W-1:0] t3x  [8] = '{32'h0000_0FF0, 32'h00F0_0000, 32'hFFF0_0000, 32'h0000_0007,
                             32'h1234_5678, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0003_0000};

  always #5 clk = ~clk;

  pipelined_barrel_shifter dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .data_i(din), .shamt_i(sh), .tag_i(tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .data_o(dout), .tag_o(tago)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [1:0] o, input logic [W-1:0] d,
                     input logic [S-1:0] s, input logic [T-1:0] t);
    in_valid = v; op = o; din = d; sh = s; tag = t;
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] d, input logic [S-1:0] s);
    case (o)
      2'b01:   return d >> s;
      2'b11:   return W'($signed(d) >>> s);
      default: return d << s;
    endcase
  endfunction

  initial begin
    // reset values
    #2;
    chk("rst_vld", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(dout), 64'(0));
    chk("rst_tag", 64'(tago), 64'(0));
    chk("rst_rdy", 64'(in_ready), 64'(1));
    @(negedge clk); rst_n = 1'b1;

    // 1: SLL 1 by 31, latency 3, one-cycle valid
    @(negedge clk); out_ready = 1'b1; drv(1'b1, 2'b00, 32'h1, 5'd31, 5'd5);
    #1 chk("t1_rdy", 64'(in_ready), 64'(1));
    @(negedge clk); drv(1'b0, 2'b00, '0, '0, '0); #1 chk("t1_lat1", 64'(out_valid), 64'(0));
    @(negedge clk); #1 chk("t1_lat2", 64'(out_valid), 64'(0));
    @(negedge clk); #1
    chk("t1_vld", 64'(out_valid), 64'(1));
    chk("t1_data", 64'(dout), 64'(32'h8000_0000));
    chk("t1_tag", 64'(tago), 64'(5));
    @(negedge clk); #1 chk("t1_vld_drop", 64'(out_valid), 64'(0));

    // 2: SRA / SRL / left-with-bit1 on the same operand
    @(negedge clk); drv(1'b1, 2'b11, 32'h8000_0000, 5'd4, 5'd1);
    @(negedge clk); drv(1'b1, 2'b01, 32'h8000_0000, 5'd4, 5'd2);
    @(negedge clk); drv(1'b1, 2'b10, 32'h8000_0000, 5'd4, 5'd3);
    @(negedge clk); drv(1'b0, 2'b00, '0, '0, '0); #1
    chk("t2_sra_vld", 64'(out_valid), 64'(1));
    chk("t2_sra", 64'(dout), 64'(32'hF800_0000));
    chk("t2_sra_tag", 64'(tago), 64'(1));
    @(negedge clk); #1
    chk("t2_srl", 64'(dout), 64'(32'h0800_0000));
    chk("t2_srl_tag", 64'(tago), 64'(2));
    @(negedge clk); #1
    chk("t2_op10_vld", 64'(out_valid), 64'(1));
    chk("t2_op10", 64'(dout), 64'(32'h0000_0000));
    chk("t2_op10_tag", 64'(tago), 64'(3));
    @(negedge clk); #1 chk("t2_idle", 64'(out_valid), 64'(0));

    // 3: eight back-to-back ops, results on consecutive cycles
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (t < 8) drv(1'b1, t3op[t], t3d[t], t3s[t], T'(10 + t));
      else       drv(1'b0, 2'b00, '0, '0, '0);
      #1;
      if (t < 8) chk("t3_rdy", 64'(in_ready), 64'(1));
      chk("t3_vld", 64'(out_valid), 64'(t >= 3 && t < 11));
      if (t >= 3 && t < 11) begin
        chk("t3_data", 64'(dout), 64'(t3x[t-3]));
        chk("t3_tag", 64'(tago), 64'(10 + t - 3));
      end
    end

    // 4: backpressure, three accepted then stall, ordered drain
    @(negedge clk); out_ready = 1'b0; drv(1'b1, 2'b01, 32'h8000_0000, 5'd1, 5'd1);
    #1 chk("t4_rdyA", 64'(in_ready), 64'(1));
    @(negedge clk); drv(1'b1, 2'b00, 32'h1, 5'd1, 5'd2); #1 chk("t4_rdyB", 64'(in_ready), 64'(1));
    @(negedge clk); drv(1'b1, 2'b11, 32'h8000_0000, 5'd1, 5'd3); #1 chk("t4_rdyC", 64'(in_ready), 64'(1));
    @(negedge clk); drv(1'b1, 2'b00, 32'hFFFF, 5'd4, 5'd4); #1
    chk("t4_rdyD", 64'(in_ready), 64'(0));
    chk("t4_hold_vld", 64'(out_valid), 64'(1));
    chk("t4_hold_data", 64'(dout), 64'(32'h4000_0000));
    @(negedge clk); #1
    chk("t4_rdyD2", 64'(in_ready), 64'(0));
    chk("t4_hold_data2", 64'(dout), 64'(32'h4000_0000));
    chk("t4_hold_tag2", 64'(tago), 64'(1));
    @(negedge clk); drv(1'b0, 2'b00, '0, '0, '0); out_ready = 1'b1; #1
    chk("t4_rdy_comb", 64'(in_ready), 64'(1));
    chk("t4_dA", 64'(dout), 64'(32'h4000_0000));
    chk("t4_tA", 64'(tago), 64'(1));
    @(negedge clk); #1
    chk("t4_vB", 64'(out_valid), 64'(1));
    chk("t4_dB", 64'(dout), 64'(32'h0000_0002));
    chk("t4_tB", 64'(tago), 64'(2));
    @(negedge clk); #1
    chk("t4_vC", 64'(out_valid), 64'(1));
    chk("t4_dC", 64'(dout), 64'(32'hC000_0000));
    chk("t4_tC", 64'(tago), 64'(3));
    @(negedge clk); #1 chk("t4_no_dup", 64'(out_valid), 64'(0));

    // 5: flush with three in flight and an op offered
    @(negedge clk); drv(1'b1, 2'b00, 32'h1, 5'd3, 5'd6);
    @(negedge clk); drv(1'b1, 2'b00, 32'h2, 5'd3, 5'd7);
    @(negedge clk); drv(1'b1, 2'b00, 32'h3, 5'd3, 5'd8);
    @(negedge clk); out_ready = 1'b0; flush = 1'b1; drv(1'b1, 2'b00, 32'hAAAA, 5'd1, 5'd9); #1
    chk("t5_rdy_flush", 64'(in_ready), 64'(0));
    chk("t5_pre_vld", 64'(out_valid), 64'(1));
    @(negedge clk); flush = 1'b0; out_ready = 1'b1; drv(1'b0, 2'b00, '0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("t5_killed", 64'(out_valid), 64'(0));
      @(negedge clk);
    end
    drv(1'b1, 2'b11, 32'h8000_0000, 5'd31, 5'd12); #1 chk("t5_rdy_after", 64'(in_ready), 64'(1));
    @(negedge clk); drv(1'b0, 2'b00, '0, '0, '0); #1 chk("t5_lat1", 64'(out_valid), 64'(0));
    @(negedge clk); #1 chk("t5_lat2", 64'(out_valid), 64'(0));
    @(negedge clk); #1
    chk("t5_vld", 64'(out_valid), 64'(1));
    chk("t5_data", 64'(dout), 64'(32'hFFFF_FFFF));
    chk("t5_tag", 64'(tago), 64'(12));

    // 6: asynchronous reset mid-stream
    @(negedge clk); drv(1'b1, 2'b01, 32'hFFFF_FFFF, 5'd4, 5'd21);
    @(negedge clk); drv(1'b1, 2'b01, 32'hFFFF_FFFF, 5'd8, 5'd22);
    @(negedge clk); drv(1'b1, 2'b01, 32'hFFFF_FFFF, 5'd12, 5'd23);
    @(negedge clk); drv(1'b0, 2'b00, '0, '0, '0); out_ready = 1'b0; #1
    chk("t6_pre_data", 64'(dout), 64'(32'h0FFF_FFFF));
    rst_n = 1'b0; #1
    chk("t6_rst_vld", 64'(out_valid), 64'(0));
    chk("t6_rst_data", 64'(dout), 64'(0));
    chk("t6_rst_tag", 64'(tago), 64'(0));
    chk("t6_rst_rdy", 64'(in_ready), 64'(1));
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t6_no_stale", 64'(out_valid), 64'(0));
      @(negedge clk);
    end

    // random ops with random stalls against the behavioural model
    while ((sent < NR || q_d.size() != 0) && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (sent < NR && $urandom_range(0, 3) != 0) begin
        ro = 2'($urandom_range(0, 3));
        rd = $urandom;
        rs = S'($urandom_range(0, 31));
        rt = T'($urandom_range(0, 31));
        drv(1'b1, ro, rd, rs, rt);
      end else drv(1'b0, 2'b00, '0, '0, '0);
      #1;
      if (out_valid && out_ready) begin
        if (q_d.size() == 0) chk("rnd_spurious", 64'(out_valid), 64'(0));
        else begin
          chk("rnd_data", 64'(dout), 64'(q_d.pop_front()));
          chk("rnd_tag", 64'(tago), 64'(q_t.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        q_d.push_back(model(op, din, sh));
        q_t.push_back(tag);
        sent++;
      end
    end
    chk("rnd_sent", 64'(sent), 64'(NR));
    chk("rnd_drained", 64'(q_d.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
